// File: rtl/vedic_seq_divider.sv
// rtl/vedic_seq_divider.sv - iterative restoring divider, one quotient bit per cycle
//
// Divides a 2W-bit dividend by a W-bit divisor behind valid/ready handshakes.
// Optional macro: VEDIC_DIV_SIGNED_EN (two's complement operands, adds a FIX state).
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    dividend/divisor valid
//   in_ready   out  1    divider can accept an operation
//   dividend   in   2W   dividend
//   divisor    in   W    divisor
//   out_valid  out  1    result valid, held until out_ready
//   out_ready  in   1    consumer accepts result
//   quotient   out  2W   quotient
//   remainder  out  W    remainder
//   div_zero   out  1    divisor was zero (qualified by out_valid)
module vedic_seq_divider #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   quotient,
    output logic [W-1:0]     remainder,
    output logic             div_zero
);

    localparam int DW = 2 * W;
    localparam int CW = $clog2(DW);

`ifdef VEDIC_DIV_SIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t          state;
    // work holds the not-yet-consumed dividend bits in its upper end while
    // quotient bits shift in from the bottom; after 2W steps it is the quotient.
    logic [DW-1:0]   work;
    logic [W:0]      rem;
    logic [W-1:0]    dvs_r;
    logic [CW-1:0]   count;

    logic [W:0]      rem_sh;
    logic [W:0]      rem_sub;
    logic [W:0]      rem_nxt;
    logic [DW-1:0]   work_nxt;
    logic            take;
    logic [DW-1:0]   dvd_mag;
    logic [W-1:0]    dvs_mag;

`ifdef VEDIC_DIV_SIGNED_EN
    logic            neg_q;
    logic            neg_r;
    logic [W-1:0]    rem_w;

    assign rem_w = W'(rem);

    // Magnitudes are formed at accept; -2^(2W-1) maps to 2^(2W-1), which
    // still fits the unsigned 2W-bit datapath, so the overflow case wraps naturally.
    always_comb begin
        dvd_mag = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
        dvs_mag = divisor[W-1]   ? (~divisor + 1'b1)  : divisor;
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
    end
`endif

    // One restoring step: the shifted partial remainder needs W+1 bits since
    // it can reach 2*divisor-1 before the trial subtraction.
    always_comb begin
        rem_sh   = (rem << 1) | (W+1)'(work[DW-1]);
        take     = (rem_sh >= {1'b0, dvs_r});
        rem_sub  = rem_sh - {1'b0, dvs_r};
        rem_nxt  = take ? rem_sub : rem_sh;
        work_nxt = {work[DW-2:0], take};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            work      <= '0;
            rem       <= '0;
            dvs_r     <= '0;
            count     <= '0;
`ifdef VEDIC_DIV_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend[W-1:0];
                            div_zero  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            work  <= dvd_mag;
                            dvs_r <= dvs_mag;
                            rem   <= '0;
                            count <= CW'(DW - 1);
`ifdef VEDIC_DIV_SIGNED_EN
                            neg_q <= dividend[DW-1] ^ divisor[W-1];
                            neg_r <= dividend[DW-1];
`endif
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    work  <= work_nxt;
                    rem   <= rem_nxt;
                    count <= count - 1'b1;
                    if (count == '0) begin
`ifdef VEDIC_DIV_SIGNED_EN
                        state <= FIX;
`else
                        quotient  <= work_nxt;
                        remainder <= W'(rem_nxt);
                        div_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end
`ifdef VEDIC_DIV_SIGNED_EN
                FIX: begin
                    quotient  <= neg_q ? (~work + 1'b1) : work;
                    remainder <= neg_r ? (~rem_w + 1'b1) : rem_w;
                    div_zero  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    // Ready rises only after the output handshake, so no accept
                    // can share a cycle with it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic_seq_divider.sv
// tb/tb_vedic_seq_divider.sv - self-checking bench for vedic_seq_divider
module tb_vedic_seq_divider;

    localparam int W  = 4;
    localparam int DW = 2 * W;
`ifdef VEDIC_DIV_SIGNED_EN
    localparam int LAT = 2 * W + 2;
`else
    localparam int LAT = 2 * W + 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [W-1:0]  remainder;
    logic          div_zero;

    int checks   = 0;
    int failures = 0;

    vedic_seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division from the arithmetic definition.
    function automatic void model(input logic [DW-1:0] a, input logic [W-1:0] b,
                                  output logic [DW-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        int sa, sb, qi, ri;
        if (b == '0) begin
            q  = '1;
            r  = a[W-1:0];
            dz = 1'b1;
        end else begin
`ifdef VEDIC_DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
`else
            sa = int'(a);
            sb = int'(b);
`endif
            qi = sa / sb;
            ri = sa % sb;
            q  = DW'(qi);
            r  = W'(ri);
            dz = 1'b0;
        end
    endfunction

    // Drives one operation, holds out_ready low for 'stall' cycles of out_valid,
    // and reports what was observed. Callers do the comparisons.
    task automatic run_op(input logic [DW-1:0] a, input logic [W-1:0] b, input int stall,
                          output logic [DW-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int lat, output bit busy_ok, output bit hold_ok,
                          output bit idle_ok);
        int n;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        idle_ok = 1'b1;
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_zero;
        for (int i = 0; i < stall; i++) begin
            if (in_ready || !out_valid || quotient !== q || remainder !== r || div_zero !== dz)
                hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        if (in_ready) busy_ok = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) idle_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, {DW{1'b0}}, {W{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dz=%b expected rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, quotient, remainder, div_zero);
        end
    endtask

    task automatic test_div_zero();
        logic [DW-1:0] q; logic [W-1:0] r; logic dz; int lat; bit b_ok, h_ok, i_ok;
        run_op(8'd13, 4'd0, 0, q, r, dz, lat, b_ok, h_ok, i_ok);
        checks++; if (q !== 8'hFF) begin failures++; $display("FAIL dz_quotient: got %h expected ff", q); end
        checks++; if (r !== 4'hD) begin failures++; $display("FAIL dz_remainder: got %h expected d", r); end
        checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dz_flag: got %b expected 1", dz); end
        checks++; if (lat != 1) begin failures++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        checks++; if (!i_ok) begin failures++; $display("FAIL dz_idle: got 0 expected 1"); end
    endtask

`ifndef VEDIC_DIV_SIGNED_EN
    task automatic test_basic();
        logic [DW-1:0] q; logic [W-1:0] r; logic dz; int lat; bit b_ok, h_ok, i_ok;
        run_op(8'd200, 4'd7, 0, q, r, dz, lat, b_ok, h_ok, i_ok);
        checks++; if (q !== 8'd28) begin failures++; $display("FAIL basic_quotient: got %0d expected 28", q); end
        checks++; if (r !== 4'd4) begin failures++; $display("FAIL basic_remainder: got %0d expected 4", r); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL basic_dz: got %b expected 0", dz); end
        checks++; if (lat != 9) begin failures++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        checks++; if (!b_ok) begin failures++; $display("FAIL basic_busy_ready: got 1 expected 0"); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] q; logic [W-1:0] r; logic dz; int lat; bit b_ok, h_ok, i_ok;
        run_op(8'd255, 4'd15, 0, q, r, dz, lat, b_ok, h_ok, i_ok);
        checks++; if ({q, r} !== {8'd17, 4'd0}) begin failures++; $display("FAIL b2b_first: got %0d r%0d expected 17 r0", q, r); end
        checks++; if (!b_ok || !i_ok) begin failures++; $display("FAIL b2b_first_ready: got busy_ok=%b idle_ok=%b expected 1 1", b_ok, i_ok); end
        run_op(8'd5, 4'd9, 0, q, r, dz, lat, b_ok, h_ok, i_ok);
        checks++; if ({q, r} !== {8'd0, 4'd5}) begin failures++; $display("FAIL b2b_second: got %0d r%0d expected 0 r5", q, r); end
        checks++; if (!b_ok || lat != 9) begin failures++; $display("FAIL b2b_second_timing: got busy_ok=%b lat=%0d expected 1 9", b_ok, lat); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] q; logic [W-1:0] r; logic dz; int lat; bit b_ok, h_ok, i_ok;
        run_op(8'd180, 4'd11, 3, q, r, dz, lat, b_ok, h_ok, i_ok);
        checks++; if ({q, r} !== {8'd16, 4'd4}) begin failures++; $display("FAIL bp_result: got %0d r%0d expected 16 r4", q, r); end
        checks++; if (!h_ok) begin failures++; $display("FAIL bp_hold: got 0 expected 1"); end
        checks++; if (!b_ok || !i_ok) begin failures++; $display("FAIL bp_ready: got busy_ok=%b idle_ok=%b expected 1 1", b_ok, i_ok); end
    endtask
`else
    task automatic test_signed();
        logic [DW-1:0] q; logic [W-1:0] r; logic dz; int lat; bit b_ok, h_ok, i_ok;
        run_op(8'hF9, 4'h2, 0, q, r, dz, lat, b_ok, h_ok, i_ok);
        checks++; if ({q, r, dz} !== {8'hFD, 4'hF, 1'b0}) begin failures++; $display("FAIL signed_neg: got %h r%h dz%b expected fd rf dz0", q, r, dz); end
        checks++; if (lat != 10) begin failures++; $display("FAIL signed_latency: got %0d expected 10", lat); end
        run_op(8'h80, 4'hF, 0, q, r, dz, lat, b_ok, h_ok, i_ok);
        checks++; if ({q, r, dz} !== {8'h80, 4'h0, 1'b0}) begin failures++; $display("FAIL signed_overflow: got %h r%h dz%b expected 80 r0 dz0", q, r, dz); end
    endtask
`endif

    task automatic test_abort();
        logic [DW-1:0] q; logic [W-1:0] r; logic dz; int lat; bit b_ok, h_ok, i_ok;
        bit stray;
        dividend = 8'd100; divisor = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, {DW{1'b0}}, {W{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL abort_reset: got rdy=%b vld=%b q=%h r=%h dz=%b expected rdy=1 vld=0 q=0 r=0 dz=0",
                     in_ready, out_valid, quotient, remainder, div_zero);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stray = 1'b1;
        end
        checks++; if (stray) begin failures++; $display("FAIL abort_no_result: got stray activity expected idle"); end
        run_op(8'd100, 4'd3, 0, q, r, dz, lat, b_ok, h_ok, i_ok);
        checks++; if ({q, r, dz} !== {8'd33, 4'd1, 1'b0}) begin failures++; $display("FAIL abort_retry: got %0d r%0d dz%b expected 33 r1 dz0", q, r, dz); end
        checks++; if (lat != LAT) begin failures++; $display("FAIL abort_retry_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_random();
        logic [DW-1:0] q, eq; logic [W-1:0] r, er; logic dz, edz; int lat, elat;
        bit b_ok, h_ok, i_ok;
        logic [DW-1:0] a; logic [W-1:0] b; int sel;
        for (int n = 0; n < 2000; n++) begin
            a   = DW'($urandom);
            sel = $urandom_range(0, 7);
            b   = (sel == 0) ? W'(0) : (sel == 1) ? W'(1) : W'($urandom);
            if ($urandom_range(0, 15) == 0) a = {1'b1, {(DW-1){1'b0}}};
            model(a, b, eq, er, edz);
            elat = (b == '0) ? 1 : LAT;
            run_op(a, b, $urandom_range(0, 2), q, r, dz, lat, b_ok, h_ok, i_ok);
            checks++;
            if ({q, r, dz} !== {eq, er, edz} || lat != elat || !b_ok || !h_ok || !i_ok) begin
                failures++;
                $display("FAIL random_op %h/%h: got q=%h r=%h dz=%b lat=%0d flags=%b%b%b expected q=%h r=%h dz=%b lat=%0d flags=111",
                         a, b, q, r, dz, lat, b_ok, h_ok, i_ok, eq, er, edz, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div_zero();
`ifndef VEDIC_DIV_SIGNED_EN
        test_basic();
        test_back_to_back();
        test_backpressure();
`else
        test_signed();
`endif
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
